// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared arbitration mode encodings and width helper
package mux_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Bits needed to index n items (n >= 2).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational fixed-priority / round-robin grant search
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          mode,
    output logic [N-1:0]  grant_onehot,
    output logic [SW-1:0] grant_idx
);

    // Fixed priority is a round-robin search that always starts at 0.
    always_comb begin
        int   start;
        int   idx;
        logic found;
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        start        = mode ? int'(ptr) : 0;
        idx          = 0;
        for (int k = 0; k < N; k++) begin
            idx = start + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found             = 1'b1;
                grant_onehot[idx] = 1'b1;
                grant_idx         = SW'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_nby1_rr.sv
// rtl/mux_nby1_rr.sv - N-to-1 arbitrated mux with a registered output stage
module mux_nby1_rr
    import mux_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 8,
    parameter  int MODE = MODE_RR,
    localparam int SW   = clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_sel,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [W-1:0]  ch_data [N];
    logic [N-1:0]  grant_onehot;
    logic [SW-1:0] grant_idx;
    logic [SW-1:0] ptr;
    logic          load;
    logic          any_valid;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*W +: W];
    end

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .req          (in_valid),
        .ptr          (ptr),
        .mode         (MODE == MODE_RR),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    // The stage can take a word whenever it is empty or being drained this cycle.
    assign load      = !out_valid || out_ready;
    assign any_valid = |in_valid;
    assign in_ready  = (load && rst_n) ? grant_onehot : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (load) begin
            if (any_valid) begin
                out_data  <= ch_data[grant_idx];
                out_sel   <= grant_idx;
                out_valid <= 1'b1;
                if (MODE == MODE_RR) begin
                    ptr <= (grant_idx == SW'(N - 1)) ? '0 : grant_idx + 1'b1;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nby1_rr.sv
// tb/tb_mux_nby1_rr.sv - directed self-checking bench for mux_nby1_rr
module tb_mux_nby1_rr;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic           clk;
    logic           rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid_rr, in_valid_fx;
    logic [N-1:0]   in_ready_rr, in_ready_fx;
    logic [W-1:0]   out_data_rr, out_data_fx;
    logic [SW-1:0]  out_sel_rr, out_sel_fx;
    logic           out_valid_rr, out_valid_fx;
    logic           out_ready_rr, out_ready_fx;

    int checks;
    int errors;

    mux_nby1_rr #(.N(N), .W(W), .MODE(1)) dut_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid_rr),
        .in_ready  (in_ready_rr),
        .out_data  (out_data_rr),
        .out_sel   (out_sel_rr),
        .out_valid (out_valid_rr),
        .out_ready (out_ready_rr)
    );

    mux_nby1_rr #(.N(N), .W(W), .MODE(0)) dut_fx (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid_fx),
        .in_ready  (in_ready_fx),
        .out_data  (out_data_fx),
        .out_sel   (out_sel_fx),
        .out_valid (out_valid_fx),
        .out_ready (out_ready_fx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        in_data      = 32'hA3A2A1A0;
        in_valid_rr  = 4'hF;
        in_valid_fx  = 4'hF;
        out_ready_rr = 1'b1;
        out_ready_fx = 1'b1;
        #1;
        checks++; if (in_ready_rr !== 4'b0000) begin errors++; $display("FAIL reset_in_ready_rr: got %b expected 0000", in_ready_rr); end
        checks++; if (in_ready_fx !== 4'b0000) begin errors++; $display("FAIL reset_in_ready_fx: got %b expected 0000", in_ready_fx); end
        in_valid_rr = 4'h0;
        in_valid_fx = 4'h0;
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++; if (out_valid_rr !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %b expected 0", out_valid_rr); end
        checks++; if (out_data_rr !== 8'h00) begin errors++; $display("FAIL idle_out_data: got %h expected 00", out_data_rr); end
        checks++; if (in_ready_rr !== 4'b0000) begin errors++; $display("FAIL idle_in_ready: got %b expected 0000", in_ready_rr); end
        checks++; if (dut_rr.ptr !== 2'd0) begin errors++; $display("FAIL idle_ptr: got %0d expected 0", dut_rr.ptr); end
    endtask

    task automatic test_rr_sequence();
        logic [1:0] exp_sel;
        in_valid_rr  = 4'hF;
        out_ready_rr = 1'b1;
        #1;
        checks++; if (in_ready_rr !== 4'b0001) begin errors++; $display("FAIL rr_first_in_ready: got %b expected 0001", in_ready_rr); end
        for (int i = 0; i < 6; i++) begin
            exp_sel = 2'(i % 4);
            step();
            checks++; if (out_valid_rr !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %b expected 1", i, out_valid_rr); end
            checks++; if (out_sel_rr !== exp_sel) begin errors++; $display("FAIL rr_sel[%0d]: got %0d expected %0d", i, out_sel_rr, exp_sel); end
            checks++; if (out_data_rr !== (8'hA0 + 8'(exp_sel))) begin errors++; $display("FAIL rr_data[%0d]: got %h expected %h", i, out_data_rr, 8'hA0 + 8'(exp_sel)); end
        end
        checks++; if (dut_rr.ptr !== 2'd2) begin errors++; $display("FAIL rr_ptr: got %0d expected 2", dut_rr.ptr); end
    endtask

    task automatic test_backpressure();
        out_ready_rr = 1'b0;
        #1;
        checks++; if (in_ready_rr !== 4'b0000) begin errors++; $display("FAIL bp_in_ready_now: got %b expected 0000", in_ready_rr); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_data_rr !== 8'hA1) begin errors++; $display("FAIL bp_data[%0d]: got %h expected a1", i, out_data_rr); end
            checks++; if (out_sel_rr !== 2'd1) begin errors++; $display("FAIL bp_sel[%0d]: got %0d expected 1", i, out_sel_rr); end
            checks++; if (out_valid_rr !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, out_valid_rr); end
            checks++; if (in_ready_rr !== 4'b0000) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0000", i, in_ready_rr); end
        end
        checks++; if (dut_rr.ptr !== 2'd2) begin errors++; $display("FAIL bp_ptr_hold: got %0d expected 2", dut_rr.ptr); end
        out_ready_rr = 1'b1;
        #1;
        checks++; if (in_ready_rr !== 4'b0100) begin errors++; $display("FAIL bp_resume_in_ready: got %b expected 0100", in_ready_rr); end
        step();
        checks++; if (out_sel_rr !== 2'd2) begin errors++; $display("FAIL bp_resume_sel: got %0d expected 2", out_sel_rr); end
        checks++; if (out_data_rr !== 8'hA2) begin errors++; $display("FAIL bp_resume_data: got %h expected a2", out_data_rr); end
        in_valid_rr = 4'h0;
        step();
        checks++; if (out_valid_rr !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b expected 0", out_valid_rr); end
        checks++; if (out_data_rr !== 8'hA2) begin errors++; $display("FAIL drain_data_hold: got %h expected a2", out_data_rr); end
        checks++; if (out_sel_rr !== 2'd2) begin errors++; $display("FAIL drain_sel_hold: got %0d expected 2", out_sel_rr); end
        checks++; if (dut_rr.ptr !== 2'd3) begin errors++; $display("FAIL drain_ptr: got %0d expected 3", dut_rr.ptr); end
    endtask

    task automatic test_wrap_sparse();
        in_valid_rr = 4'b0001;
        #1;
        checks++; if (in_ready_rr !== 4'b0001) begin errors++; $display("FAIL wrap_in_ready: got %b expected 0001", in_ready_rr); end
        step();
        checks++; if (out_sel_rr !== 2'd0) begin errors++; $display("FAIL wrap_sel: got %0d expected 0", out_sel_rr); end
        checks++; if (out_data_rr !== 8'hA0) begin errors++; $display("FAIL wrap_data: got %h expected a0", out_data_rr); end
        checks++; if (dut_rr.ptr !== 2'd1) begin errors++; $display("FAIL wrap_ptr: got %0d expected 1", dut_rr.ptr); end
        in_valid_rr = 4'h0;
        step();
        checks++; if (out_valid_rr !== 1'b0) begin errors++; $display("FAIL sparse_valid_drop: got %b expected 0", out_valid_rr); end
    endtask

    task automatic test_fixed();
        in_valid_fx  = 4'b1010;
        out_ready_fx = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (in_ready_fx !== 4'b0010) begin errors++; $display("FAIL fx_in_ready[%0d]: got %b expected 0010", i, in_ready_fx); end
            step();
            checks++; if (out_sel_fx !== 2'd1) begin errors++; $display("FAIL fx_sel[%0d]: got %0d expected 1", i, out_sel_fx); end
            checks++; if (out_data_fx !== 8'hA1) begin errors++; $display("FAIL fx_data[%0d]: got %h expected a1", i, out_data_fx); end
            checks++; if (dut_fx.ptr !== 2'd0) begin errors++; $display("FAIL fx_ptr[%0d]: got %0d expected 0", i, dut_fx.ptr); end
        end
        in_valid_fx = 4'h0;
    endtask

    task automatic test_reset_mid_hold();
        in_valid_rr  = 4'b1100;
        out_ready_rr = 1'b0;
        step();
        checks++; if (out_sel_rr !== 2'd2) begin errors++; $display("FAIL hold_sel: got %0d expected 2", out_sel_rr); end
        checks++; if (out_valid_rr !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b expected 1", out_valid_rr); end
        step();
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid_rr !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %b expected 0", out_valid_rr); end
        checks++; if (out_data_rr !== 8'h00) begin errors++; $display("FAIL async_rst_data: got %h expected 00", out_data_rr); end
        checks++; if (out_sel_rr !== 2'd0) begin errors++; $display("FAIL async_rst_sel: got %0d expected 0", out_sel_rr); end
        checks++; if (dut_rr.ptr !== 2'd0) begin errors++; $display("FAIL async_rst_ptr: got %0d expected 0", dut_rr.ptr); end
        checks++; if (in_ready_rr !== 4'b0000) begin errors++; $display("FAIL async_rst_in_ready: got %b expected 0000", in_ready_rr); end
        step();
        in_valid_rr  = 4'b0110;
        out_ready_rr = 1'b1;
        rst_n        = 1'b1;
        #1;
        checks++; if (in_ready_rr !== 4'b0010) begin errors++; $display("FAIL post_rst_in_ready: got %b expected 0010", in_ready_rr); end
        step();
        checks++; if (out_sel_rr !== 2'd1) begin errors++; $display("FAIL post_rst_sel: got %0d expected 1", out_sel_rr); end
        checks++; if (out_data_rr !== 8'hA1) begin errors++; $display("FAIL post_rst_data: got %h expected a1", out_data_rr); end
        step();
        checks++; if (out_sel_rr !== 2'd2) begin errors++; $display("FAIL post_rst_next_sel: got %0d expected 2", out_sel_rr); end
        in_valid_rr = 4'h0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rr_sequence();
        test_backpressure();
        test_wrap_sparse();
        test_fixed();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_nby1_rr.md
MUX_NBY1_RR -- requirements
Module: mux_nby1_rr

Interface
REQ-001 Parameter N, default 4, number of input channels (legal 2..16).
REQ-002 Parameter W, default 8, data width per channel in bits (legal 1..64).
REQ-003 Parameter MODE, default 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-004 Parameter SW, derived as ceil(log2(N)), the width of the select field; it shall not be overridable.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_data  input  N*W  packed channel data; channel i occupies bits [i*W+W-1 : i*W].
REQ-008 in_valid  input  N  per-channel request; bit i set means channel i offers a word.
REQ-009 in_ready  output  N  per-channel accept, one-hot or zero, combinational.
REQ-010 out_data  output  W  registered selected word.
REQ-011 out_sel  output  SW  registered index of the channel that supplied out_data.
REQ-012 out_valid  output  1  registered; out_data and out_sel hold a word.
REQ-013 out_ready  input  1  downstream accepts the word when it is high together with out_valid.

Function
REQ-014 The internal load signal shall be defined as load = !out_valid || out_ready.
REQ-015 In MODE 0, grant shall go to the lowest-index channel with in_valid set.
REQ-016 In MODE 1, grant shall go to the first channel with in_valid set, searching from ptr upward and wrapping from N-1 to 0.
REQ-017 in_ready[i] shall be high only when load=1, rst_n=1 and channel i holds the grant; at most one bit shall be high.
REQ-018 On a clock edge with load=1 and a grant g: out_data <= channel g data, out_sel <= g, out_valid <= 1.
REQ-019 On a clock edge with load=1 and no in_valid bit set: out_valid <= 0, and out_data and out_sel shall hold their values.
REQ-020 While out_valid=1 and out_ready=0, out_data, out_sel and out_valid shall remain stable and every in_ready bit shall be 0.
REQ-021 Latency from input transfer to out_valid shall be 1 cycle.
REQ-022 Sustained throughput shall be 1 word per cycle while out_ready=1.
REQ-023 In MODE 1, ptr shall update to (g+1) mod N on each input transfer; g=N-1 wraps ptr to 0.
REQ-024 In MODE 1, ptr shall be unchanged on any cycle without an input transfer.
REQ-025 In MODE 1, a channel that holds in_valid continuously shall be granted within N transfers (no starvation).
REQ-026 In MODE 0, ptr shall be unused and held at 0.
REQ-027 A simultaneous output drain and input load in the same cycle shall be accepted with no bubble.
REQ-028 When N is not a power of two, ptr shall never take a value of N or greater.

Reset
REQ-029 While rst_n=0: out_valid=0, out_data=0, out_sel=0, ptr=0, and in_ready=0 regardless of inputs.
REQ-030 Reset asserted mid-operation shall discard any held word immediately, with no waiting for a clock edge.
REQ-031 The first grant after reset release shall go to the lowest-index valid channel, in both modes.

Structure
REQ-032 The MODE encodings (MODE_FIXED=0, MODE_RR=1) and the clog2 helper function shall reside in the shared package mux_pkg.
REQ-033 Grant logic shall be a sub-module rr_arbiter with ports req[N], ptr[SW], mode, grant_onehot[N] and grant_idx[SW].
REQ-034 The output register stage shall be contained in mux_nby1_rr itself.

Verification (N=4, W=8 unless stated)
REQ-035 Reset then idle: rst_n low for 2 cycles, then high, all in_valid=0 -> out_valid=0, out_data=0x00, in_ready=4'b0000.
REQ-036 MODE 1, all four channels valid with data 0xA0..0xA3, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, with out_data matching each channel.
REQ-037 Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> out_data held at 0xA1 and in_ready=0; out_ready=1 then resumes with out_sel=2.
REQ-038 MODE 0, in_valid=4'b1010 steady, out_ready=1 -> out_sel=1 on every cycle and channel 3 is never granted.
REQ-039 Wrap and sparse: MODE 1, ptr=3, in_valid=4'b0001 -> grant goes to channel 0 and ptr becomes 1; then in_valid=0 -> out_valid drops to 0 on the next edge.
REQ-040 Reset mid-hold: out_valid=1 with out_ready=0, rst_n pulsed low between clock edges -> out_valid=0 immediately, and the first post-reset grant goes to the lowest-index valid channel.
